// File: rtl/mul_k_pipe_if.sv
// Operand/product channel of mul_k_pipe: A/B pair in, unreduced product out, plus pipeline flush.
// Names are seen from the multiplier's side. RANGE_CHECK_EN adds the sticky range_err_o signal.
interface mul_k_pipe_if #(
    parameter int NB_BIT = 12
);
    logic                  clear_i;
    logic [NB_BIT-1:0]     a_i;
    logic [NB_BIT-1:0]     b_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [2*NB_BIT-1:0]   product_o;
    logic                  valid_o;
    logic                  ready_i;
`ifdef RANGE_CHECK_EN
    logic                  range_err_o;

    modport master (
        output clear_i, a_i, b_i, valid_i, ready_i,
        input  ready_o, product_o, valid_o, range_err_o
    );

    modport slave (
        input  clear_i, a_i, b_i, valid_i, ready_i,
        output ready_o, product_o, valid_o, range_err_o
    );
`else
    modport master (
        output clear_i, a_i, b_i, valid_i, ready_i,
        input  ready_o, product_o, valid_o
    );

    modport slave (
        input  clear_i, a_i, b_i, valid_i, ready_i,
        output ready_o, product_o, valid_o
    );
`endif
endinterface

// File: rtl/mul_k_pipe.sv
// Purpose: unsigned NB_BIT x NB_BIT coefficient multiply, full 2*NB_BIT product for the Barrett reducer; RANGE_CHECK_EN adds sticky range_err_o.
// Latency: 2 cycles (S1 operand register, S2 product register), one pair per cycle sustained.
// Backpressure: ready_o = !v1 || !v2 || ready_i, combinational from ready_i; a full pipe drains and refills in the same cycle.
module mul_k_pipe #(
    parameter int NB_BIT = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mul_k_pipe_if.slave bus
);

    logic                  v1;
    logic                  v2;
    logic [NB_BIT-1:0]     a1;
    logic [NB_BIT-1:0]     b1;
    logic [2*NB_BIT-1:0]   prod2;
    logic [2*NB_BIT-1:0]   prod_s1;
    logic                  mv1;
    logic                  mv2;

    // S2 may load whenever it is empty or its product leaves this cycle; S1 follows S2.
    always_comb begin
        mv2 = !v2 || bus.ready_i;
        mv1 = !v1 || mv2;
    end

    assign prod_s1 = {{NB_BIT{1'b0}}, a1} * {{NB_BIT{1'b0}}, b1};

    assign bus.ready_o   = mv1;
    assign bus.valid_o   = v2;
    assign bus.product_o = prod2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            a1    <= '0;
            b1    <= '0;
            prod2 <= '0;
        end else if (bus.clear_i) begin
            // Flush wins over any accept or transfer in the same cycle.
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (mv2) begin
                v2 <= v1;
                if (v1) begin
                    prod2 <= prod_s1;
                end
            end
            if (mv1) begin
                v1 <= bus.valid_i;
                if (bus.valid_i) begin
                    a1 <= bus.a_i;
                    b1 <= bus.b_i;
                end
            end
        end
    end

`ifdef RANGE_CHECK_EN
    localparam int unsigned Q_MOD = 3329;

    logic range_err;
    logic accept;
    logic oor;

    assign accept = bus.valid_i && mv1 && !bus.clear_i;
    assign oor    = (32'(bus.a_i) >= Q_MOD) || (32'(bus.b_i) >= Q_MOD);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            range_err <= 1'b0;
        end else if (bus.clear_i) begin
            range_err <= 1'b0;
        end else if (accept && oor) begin
            range_err <= 1'b1;
        end
    end

    assign bus.range_err_o = range_err;
`endif

endmodule

// File: doc/mul_k_pipe.md
MUL_K_PIPE -- requirements
Module: mul_k_pipe

Interface
REQ-001 Parameter: NB_BIT, default 12, coefficient width; product width is 2*NB_BIT (24 at default, matching the Barrett reduction input).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 clear_i  input  1  synchronous flush of pipeline contents.
REQ-005 a_i  input  NB_BIT  coefficient operand A, unsigned.
REQ-006 b_i  input  NB_BIT  coefficient operand B (e.g. twiddle), unsigned.
REQ-007 valid_i  input  1  A/B pair valid.
REQ-008 ready_o  output  1  block can accept a pair this cycle.
REQ-009 product_o  output  2*NB_BIT  registered unsigned product a*b, fed unreduced to the Barrett reducer.
REQ-010 valid_o  output  1  product_o valid.
REQ-011 ready_i  input  1  downstream accepts product this cycle.
REQ-012 range_err_o  output  1  sticky operand range error; present only with RANGE_CHECK_EN (REQ-030).

Function
REQ-013 Two-stage pipeline; stage S1 holds registered a/b plus valid flag v1; stage S2 holds registered product plus valid flag v2.
REQ-014 Input handshake: pair accepted when valid_i && ready_o on a rising edge; output transfer when valid_o && ready_i.
REQ-015 valid_o SHALL equal v2; product_o SHALL equal S2 product register (no combinational path from a_i/b_i).
REQ-016 S2 advances (mv2) when !v2 || ready_i; S1 advances (mv1) when !v1 || mv2; ready_o = mv1 (combinational from ready_i, documented).
REQ-017 On mv2: v2 <= v1, S2 product <= S1.a * S1.b (full 2*NB_BIT width, no truncation); if !v1, product register holds its previous value.
REQ-018 On mv1: v1 <= valid_i, S1 <= a_i/b_i when valid_i; otherwise S1 data holds.
REQ-019 Latency: accepted pair appears on valid_o exactly 2 cycles after acceptance edge when ready_i stays high.
REQ-020 Throughput: one pair per cycle sustained while ready_i high; no bubbles inserted.
REQ-021 Stall: with v2=1 and ready_i=0, product_o and valid_o SHALL remain stable until transfer; S1 fills, then ready_o deasserts; no data lost or duplicated.
REQ-022 Full: v1=v2=1 and ready_i=0 => ready_o=0; ready_i rising => same-cycle ready_o=1 (simultaneous drain and fill allowed).
REQ-023 Empty: v1=v2=0 => valid_o=0, ready_o=1 regardless of ready_i.
REQ-024 Ordering: products emerge in acceptance order.
REQ-025 clear_i=1: v1,v2 <= 0 next edge, overriding any simultaneous accept or transfer; accept in that cycle is discarded; data registers need not clear.
REQ-026 Max product at NB_BIT=12 with in-range operands: 3328*3328 = 11075584 < 2^24.

Reset
REQ-027 rst_i assertion asynchronously forces v1=0, v2=0, valid_o=0, product_o=0, S1 data=0 (and range_err_o=0 when present).
REQ-028 Reset mid-operation discards all in-flight pairs; after rst_i deasserts, ready_o=1 and first valid output occurs 2 cycles after first accept.
REQ-029 Data output product_o SHALL reset to 0; all registers are on the async reset.

Configuration
REQ-030 Macro RANGE_CHECK_EN: when defined, range_err_o exists and is set on any accepted pair with a_i>=3329 or b_i>=3329, sticky until rst_i or clear_i; product still computed normally.
REQ-031 Without RANGE_CHECK_EN: no range_err_o port, no comparator logic; all other behaviour identical.

Verification
REQ-032 Single pair a=3328,b=3328, ready_i=1 -> valid_o high 2 cycles after accept, product_o=11075584, then valid_o low.
REQ-033 Stream 100 random in-range pairs back-to-back, ready_i=1 -> 100 products in order, one per cycle, zero bubbles, each = a*b.
REQ-034 Stream with ready_i random 50% -> products unchanged while stalled, none lost/duplicated, ready_o low only when v1=v2=1 and ready_i=0.
REQ-035 Two pairs in flight (17*5, 1000*3000), pulse clear_i with valid_i=1 -> no valid_o after clear, next accepted 2*3 gives product_o=6 after 2 cycles.
REQ-036 Assert rst_i asynchronously between edges with pipeline full -> valid_o=0, product_o=0 immediately; ready_o=1 after release.
REQ-037 RANGE_CHECK_EN: accept a=3329,b=1 -> range_err_o=1 next cycle, product_o=3329 at latency 2; clear_i -> range_err_o=0.
